// File: rtl/ps2_key_state_tracker_pkg.sv
// ps2_key_state_tracker_pkg: shared decoder states, PS/2 byte constants and the set-2 key table
package ps2_key_state_tracker_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK} ps2State_t;
  localparam int NUMBEROFKEYBOARDINPUTS = 29;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_EE = 8'hEE;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;
  // Position in this table is the key index: tilde, 1-0, -, =, bksp, tab, Q-P, [, ], \, space
  localparam logic [0:NUMBEROFKEYBOARDINPUTS-1][7:0] KEY_CODES = {
    8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};
  function automatic logic isClearByte(input logic [7:0] b);
    return b == BYTE_00 || b == BYTE_FF || b == BYTE_AA;
  endfunction
  function automatic logic isIgnoredByte(input logic [7:0] b);
    return b == BYTE_FA || b == BYTE_EE || b == BYTE_FE;
  endfunction
endpackage

// File: rtl/ps2_scancode_map.sv
// ps2_scancode_map: combinational lookup of {ext, code} into a key index
module ps2_scancode_map
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             ext,
  input  logic [7:0]       code,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUMBEROFKEYBOARDINPUTS; i++)
      if (!ext && code == KEY_CODES[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/ps2_key_state_tracker.sv
// ps2_key_state_tracker: PS/2 set-2 make/break decoder with per-key state and press/release events.
// Define KEY_EVENT_FIFO_EN to add a FIFO of {is_release, key_idx} events.
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int NUM_KEYS       = 29,
  parameter int IDX_W          = 5,
  parameter int CNT_W          = 5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [IDX_W-1:0]    event_key,
  output logic                unmapped_pulse,
  output logic                any_key_down,
  output logic [CNT_W-1:0]    keys_held,
  input  logic                evt_rd,
  output logic [IDX_W:0]      evt_data,
  output logic                evt_empty,
  output logic                evt_overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  ps2State_t state, stateNext;
  logic [TW-1:0] tCnt;
  logic isF0, isE0, finExt, finBrk, doFinal, doClear, hit, doPress, doRelease, doUnmapped;
  logic [IDX_W-1:0] mapIdx;

  assign isF0   = rx_data == BYTE_F0;
  assign isE0   = rx_data == BYTE_E0;
  assign finExt = state == S_EXT || state == S_EXT_BREAK;
  assign finBrk = state == S_BREAK || state == S_EXT_BREAK;

  always_comb begin
    stateNext = state;
    doFinal   = 1'b0;
    doClear   = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE: begin
          stateNext = isF0 ? S_BREAK : isE0 ? S_EXT : S_IDLE;
          doClear   = isClearByte(rx_data);
          doFinal   = !isF0 && !isE0 && !doClear && !isIgnoredByte(rx_data);
        end
        S_EXT: begin
          stateNext = isF0 ? S_EXT_BREAK : isE0 ? S_EXT : S_IDLE;
          doFinal   = !isF0 && !isE0;
        end
        default: begin
          stateNext = S_IDLE;
          doFinal   = !isF0 && !isE0;
        end
      endcase
    end else if (state != S_IDLE && tCnt == TW'(TIMEOUT_CYCLES - 1))
      stateNext = S_IDLE;
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      tCnt  <= '0;
    end else begin
      state <= stateNext;
      tCnt  <= (rx_valid || stateNext == S_IDLE) ? '0 : tCnt + TW'(1);
    end

  ps2_scancode_map #(.IDX_W(IDX_W)) u_map (
    .ext  (finExt),
    .code (rx_data),
    .hit  (hit),
    .idx  (mapIdx)
  );

  // Typematic repeats and breaks of keys already up are absorbed here
  assign doPress    = doFinal && hit && !finBrk && !key_state[mapIdx];
  assign doRelease  = doFinal && hit && finBrk && key_state[mapIdx];
  assign doUnmapped = doFinal && !hit;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      key_state      <= '0;
      keys_held      <= '0;
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      unmapped_pulse <= 1'b0;
      event_key      <= '0;
    end else begin
      press_pulse    <= doPress;
      release_pulse  <= doRelease;
      unmapped_pulse <= doUnmapped;
      if (doClear) begin
        key_state <= '0;
        keys_held <= '0;
      end else if (doPress) begin
        key_state[mapIdx] <= 1'b1;
        keys_held         <= keys_held + CNT_W'(1);
      end else if (doRelease) begin
        key_state[mapIdx] <= 1'b0;
        keys_held         <= keys_held - CNT_W'(1);
      end
      if (doPress || doRelease) event_key <= mapIdx;
    end

  assign any_key_down = |key_state;

`ifdef KEY_EVENT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [IDX_W:0] fifoMem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic push, pop, full, doPush;

  assign push      = press_pulse | release_pulse;
  assign evt_empty = wrPtr == rdPtr;
  assign full      = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
  assign pop       = evt_rd && !evt_empty;
  assign doPush    = push && (!full || pop);
  assign evt_data  = evt_empty ? '0 : fifoMem[rdPtr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop) rdPtr <= rdPtr + (AW+1)'(1);
      if (push && full && !pop) evt_overflow <= 1'b1;
    end

  always_ff @(posedge clock)
    if (doPush) fifoMem[wrPtr[AW-1:0]] <= {release_pulse, event_key};
`else
  logic unusedEvtRd;
  assign unusedEvtRd  = evt_rd ^ (FIFO_DEPTH > 0);
  assign evt_empty    = 1'b1;
  assign evt_data     = '0;
  assign evt_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// tb_ps2_key_state_tracker: directed vector table, timeout/reset sequences and a randomized run against a key-state model
module tb_ps2_key_state_tracker;
  localparam int T = 16, NK = 29, DEPTH = 8;
  logic clock = 1'b0, resetn = 1'b0, rx_valid = 1'b0, evt_rd = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [NK-1:0] key_state;
  logic press_pulse, release_pulse, unmapped_pulse, any_key_down, evt_empty, evt_overflow;
  logic [4:0] event_key, keys_held;
  logic [5:0] evt_data;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  ps2_key_state_tracker #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_key(event_key), .unmapped_pulse(unmapped_pulse), .any_key_down(any_key_down),
    .keys_held(keys_held), .evt_rd(evt_rd), .evt_data(evt_data), .evt_empty(evt_empty),
    .evt_overflow(evt_overflow)
  );

  logic [7:0] codes [NK] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                             8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                             8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};

  typedef struct {
    logic [7:0] d;
    bit p, r, u;
    int k, h;
    logic [NK-1:0] s;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] d, bit p, bit r, bit u, int k, int h, logic [NK-1:0] s);
    vec_t v;
    v.d = d; v.p = p; v.r = r; v.u = u; v.k = k; v.h = h; v.s = s;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    rx_valid = 1'b0;
    evt_rd = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_state", key_state, 0);
    chk("rst_pulses", {press_pulse, release_pulse, unmapped_pulse}, 0);
    chk("rst_key_held", {event_key, keys_held, any_key_down}, 0);
    chk("rst_fifo", {evt_data, evt_empty, evt_overflow}, 2);
    resetn = 1'b1;
  endtask

  // Reference model: decoded from the protocol rules directly
  logic [NK-1:0] mKeys;
  bit mExt, mBrk, mP, mR, mU, mOvf;
  int mGap, mKey;
  logic [5:0] mq[$];

  function automatic int lookup(logic [7:0] d);
    for (int i = 0; i < NK; i++) if (codes[i] == d) return i;
    return -1;
  endfunction

  task automatic fin(input logic [7:0] d, input bit ext, input bit brk);
    int idx = lookup(d);
    if (ext || idx < 0) mU = 1;
    else if (!brk && !mKeys[idx]) begin mKeys[idx] = 1; mP = 1; mKey = idx; end
    else if (brk && mKeys[idx]) begin mKeys[idx] = 0; mR = 1; mKey = idx; end
  endtask

  task automatic mReset();
    mKeys = '0; mExt = 0; mBrk = 0; mP = 0; mR = 0; mU = 0; mOvf = 0; mGap = 0; mKey = 0;
    mq.delete();
  endtask

  task automatic mStep(input bit v, input logic [7:0] d);
`ifdef KEY_EVENT_FIFO_EN
    if (evt_rd && mq.size() > 0) void'(mq.pop_front());
    if (mP || mR) begin
      if (mq.size() < DEPTH) mq.push_back({mR, 5'(mKey)});
      else mOvf = 1;
    end
`endif
    mP = 0; mR = 0; mU = 0;
    if (v) begin
      mGap = 0;
      if (!mExt && !mBrk) begin
        if (d == 8'hF0) mBrk = 1;
        else if (d == 8'hE0) mExt = 1;
        else if (d inside {8'hAA, 8'h00, 8'hFF}) mKeys = '0;
        else if (!(d inside {8'hFA, 8'hEE, 8'hFE})) fin(d, 0, 0);
      end else if (mBrk) begin
        if (!(d inside {8'hE0, 8'hF0})) fin(d, mExt, 1);
        mExt = 0; mBrk = 0;
      end else begin
        if (d == 8'hF0) mBrk = 1;
        else if (d != 8'hE0) begin fin(d, 1, 0); mExt = 0; end
      end
    end else if (mExt || mBrk) begin
      mGap++;
      if (mGap >= T) begin mExt = 0; mBrk = 0; end
    end
  endtask

  function automatic logic [7:0] pickByte();
    int r = $urandom_range(0, 15);
    logic [7:0] sp [6] = '{8'hAA, 8'h00, 8'hFF, 8'hFA, 8'hEE, 8'hFE};
    if (r <= 6) return codes[$urandom_range(0, NK - 1)];
    if (r <= 9) return 8'hF0;
    if (r <= 11) return 8'hE0;
    if (r == 12) return sp[$urandom_range(0, 5)];
    if (r == 13) return 8'h75;
    return 8'($urandom);
  endfunction

  initial begin
    int lastKey = 0;
    int idleRun = 0;
    bit v;
    logic [7:0] d;
    doReset();
    vecs.push_back(mk(8'h15, 1, 0, 0, 15, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 1, 0, 15, 0, 29'h0));
    vecs.push_back(mk(8'h16, 1, 0, 0, 1, 1, 29'h2));
    vecs.push_back(mk(8'h1E, 1, 0, 0, 2, 2, 29'h6));
    vecs.push_back(mk(8'h29, 1, 0, 0, 28, 3, 29'h1000_0006));
    vecs.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h1E, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h75, 0, 0, 1, 0, 0, 29'h0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h75, 0, 0, 1, 0, 0, 29'h0));
    vecs.push_back(mk(8'h15, 1, 0, 0, 15, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 1, 29'h0000_8000));
    vecs.push_back(mk(8'h15, 0, 1, 0, 15, 0, 29'h0));
    vecs.push_back(mk(8'hFA, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hEE, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hFE, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h0E, 1, 0, 0, 0, 1, 29'h1));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h4D, 1, 0, 0, 24, 1, 29'h0100_0000));
    vecs.push_back(mk(8'hFF, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h4D, 0, 0, 1, 0, 0, 29'h0));
    vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h75, 0, 0, 1, 0, 0, 29'h0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 29'h0));
    vecs.push_back(mk(8'h15, 0, 0, 1, 0, 0, 29'h0));
    foreach (vecs[i]) begin
      tick(1, vecs[i].d);
      chk("tbl_pulses", {press_pulse, release_pulse, unmapped_pulse}, {vecs[i].p, vecs[i].r, vecs[i].u});
      chk("tbl_held", keys_held, vecs[i].h);
      chk("tbl_state", key_state, vecs[i].s);
      chk("tbl_any", any_key_down, vecs[i].s != 0);
      if (vecs[i].p || vecs[i].r) lastKey = vecs[i].k;
      chk("tbl_key", event_key, lastKey);
      tick(0, 8'h00);
      chk("tbl_pulse_len", {press_pulse, release_pulse, unmapped_pulse}, 0);
      chk("tbl_key_hold", event_key, lastKey);
    end
    // Break prefix abandoned after the idle timeout: the next byte is a make
    tick(1, 8'hF0);
    repeat (T) tick(0, 8'h00);
    tick(1, 8'h15);
    chk("timeout_make", {press_pulse, release_pulse, keys_held}, {2'b10, 5'd1});
    tick(1, 8'hF0);
    repeat (T - 2) tick(0, 8'h00);
    tick(1, 8'h15);
    chk("pre_timeout_break", {press_pulse, release_pulse, keys_held}, {2'b01, 5'd0});
    tick(1, 8'hE0);
    repeat (T) tick(0, 8'h00);
    tick(1, 8'h0E);
    chk("ext_timeout_make", {press_pulse, unmapped_pulse, event_key}, {2'b10, 5'd0});
    tick(1, 8'h15);
    tick(1, 8'hF0);
    doReset();
    tick(1, 8'h15);
    chk("reset_drops_prefix", {press_pulse, release_pulse, keys_held}, {2'b10, 5'd1});
    doReset();
    mReset();
    repeat (3000) begin
      if (idleRun > 0) begin v = 0; idleRun--; end
      else if ($urandom_range(0, 39) == 0) begin v = 0; idleRun = $urandom_range(T - 2, T + 1); end
      else v = ($urandom_range(0, 2) == 0);
      d = pickByte();
      evt_rd = ($urandom_range(0, 3) == 0);
      mStep(v, d);
      tick(v, d);
      chk("rnd_state", key_state, mKeys);
      chk("rnd_pulses", {press_pulse, release_pulse, unmapped_pulse}, {mP, mR, mU});
      chk("rnd_held", {any_key_down, keys_held}, {mKeys != 0, 5'($countones(mKeys))});
      chk("rnd_key", event_key, mKey);
      chk("rnd_fifo_flags", {evt_empty, evt_overflow}, {mq.size() == 0, mOvf});
      if (mq.size() > 0) chk("rnd_fifo_head", evt_data, mq[0]);
      else chk("rnd_fifo_idle", evt_data, 0);
    end
    evt_rd = 1'b0;
`ifdef KEY_EVENT_FIFO_EN
    doReset();
    for (int i = 0; i < 9; i++) tick(1, codes[i]);
    tick(0, 8'h00);
    chk("fifo_overflow", {evt_overflow, evt_empty}, 2'b10);
    for (int i = 0; i < 8; i++) begin
      chk("fifo_order", evt_data, i);
      evt_rd = 1'b1;
      tick(0, 8'h00);
      evt_rd = 1'b0;
    end
    chk("fifo_drained", {evt_empty, evt_overflow}, 2'b11);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
